// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared state encoding, frame layout and counter widths for the DHT11 poll scheduler
package dht_pkg;

  // One-hot so the state register can drive the LED bar directly.
  typedef enum logic [4:0] {
    S_HOLDOFF = 5'b00001,
    S_START   = 5'b00010,
    S_WAIT    = 5'b00100,
    S_EVAL    = 5'b01000,
    S_BACKOFF = 5'b10000
  } state_t;

  localparam int BYTE_RH_INT = 4;
  localparam int BYTE_RH_DEC = 3;
  localparam int BYTE_T_INT  = 2;
  localparam int BYTE_T_DEC  = 1;
  localparam int BYTE_CHKSUM = 0;

  localparam int MS_W = 16;
  localparam int US_W = 10;

  function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int idx);
    return 8'(frame >> (8 * idx));
  endfunction

endpackage

// File: rtl/dht_tick_gen.sv
// rtl/dht_tick_gen.sv - 1 ms tick from a CLK_PER_US prescaler and a 1000:1 microsecond divider
module dht_tick_gen import dht_pkg::*; #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick_ms
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [US_W-1:0]  us_cnt;
  logic             tick_us;

  assign tick_us = (pre_cnt == PRE_W'(CLK_PER_US - 1));
  assign tick_ms = tick_us && (us_cnt == US_W'(999));

  // clr restarts the phase so the first tick lands exactly 1 ms after a state entry.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else begin
      pre_cnt <= tick_us ? '0 : pre_cnt + 1'b1;
      if (tick_us) us_cnt <= tick_ms ? '0 : us_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_poll_sched.sv
// rtl/dht11_poll_sched.sv - DHT11 measurement scheduler; DHT_CHECKSUM_EN enables frame validation
module dht11_poll_sched import dht_pkg::*; #(
  parameter int CLK_PER_US = 100,
  parameter int PERIOD_MS  = 3000,
  parameter int MIN_GAP_MS = 1000,
  parameter int TIMEOUT_MS = 30,
  parameter int BACKOFF_MS = 1200,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        auto_en,
  input  logic        req_now,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [39:0] eng_data,
  output logic        eng_start,
  output logic        eng_abort,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic        data_valid,
  output logic        fault,
  output logic [7:0]  err_cnt,
  output logic [4:0]  state_dbg
);

  localparam logic [MS_W-1:0] PERIOD_LIM  = MS_W'(PERIOD_MS);
  localparam logic [MS_W-1:0] GAP_LIM     = MS_W'(MIN_GAP_MS);
  localparam logic [MS_W-1:0] TIMEOUT_LIM = MS_W'(TIMEOUT_MS);
  localparam logic [MS_W-1:0] BACKOFF_LIM = MS_W'(BACKOFF_MS);
  localparam logic [7:0]      RETRY_LIM   = 8'(MAX_RETRY);

  state_t          state, state_next;
  logic [MS_W-1:0] ms_cnt;
  logic [7:0]      retry;
  logic            pend;
  logic [7:0]      cand_hum, cand_temp;
  logic            frame_ok, frame_good;
  logic            tick_ms, clr;
  logic            hold_start, capture, accept, attempt_fail;

  dht_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick_ms (tick_ms)
  );

`ifdef DHT_CHECKSUM_EN
  logic [7:0] byte_sum;
  always_comb begin
    byte_sum   = frame_byte(eng_data, BYTE_RH_INT) + frame_byte(eng_data, BYTE_RH_DEC)
               + frame_byte(eng_data, BYTE_T_INT)  + frame_byte(eng_data, BYTE_T_DEC);
    frame_good = (byte_sum == frame_byte(eng_data, BYTE_CHKSUM))
               && (frame_byte(eng_data, BYTE_RH_INT) <= 8'd100);
  end
`else
  logic unused_frame_bits;
  assign unused_frame_bits = ^{eng_data[31:24], eng_data[15:0]};
  assign frame_good        = 1'b1;
`endif

  always_comb begin
    state_next   = state;
    eng_start    = 1'b0;
    eng_abort    = 1'b0;
    hold_start   = 1'b0;
    capture      = 1'b0;
    accept       = 1'b0;
    attempt_fail = 1'b0;
    unique case (state)
      S_HOLDOFF: begin
        if (ms_cnt >= GAP_LIM && (pend || (auto_en && ms_cnt >= PERIOD_LIM)) && !eng_busy) begin
          hold_start = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        eng_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A frame arriving on the timeout cycle is still evaluated.
        if (eng_done) begin
          capture    = 1'b1;
          state_next = S_EVAL;
        end else if (ms_cnt >= TIMEOUT_LIM) begin
          eng_abort    = 1'b1;
          attempt_fail = 1'b1;
        end
      end
      S_EVAL: begin
        if (frame_ok) begin
          accept     = 1'b1;
          state_next = S_HOLDOFF;
        end else begin
          attempt_fail = 1'b1;
        end
      end
      S_BACKOFF: begin
        if (ms_cnt >= BACKOFF_LIM && !eng_busy) state_next = S_START;
      end
      default: state_next = S_HOLDOFF;
    endcase
    if (attempt_fail) state_next = (retry < RETRY_LIM) ? S_BACKOFF : S_HOLDOFF;
  end

  assign clr       = (state_next != state);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_HOLDOFF;
      ms_cnt      <= '0;
      retry       <= '0;
      pend        <= 1'b0;
      cand_hum    <= '0;
      cand_temp   <= '0;
      frame_ok    <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      fault       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state <= state_next;
      if (clr)                          ms_cnt <= '0;
      else if (tick_ms && ms_cnt != '1) ms_cnt <= ms_cnt + 1'b1;
      if (hold_start)   pend <= 1'b0;
      else if (req_now) pend <= 1'b1;
      if (hold_start)                            retry <= '0;
      else if (attempt_fail && retry < RETRY_LIM) retry <= retry + 1'b1;
      if (capture) begin
        cand_hum  <= frame_byte(eng_data, BYTE_RH_INT);
        cand_temp <= frame_byte(eng_data, BYTE_T_INT);
        frame_ok  <= frame_good;
      end
      if (accept) begin
        humidity    <= cand_hum;
        temperature <= cand_temp;
        data_valid  <= 1'b1;
        fault       <= 1'b0;
      end
      if (attempt_fail) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        if (retry >= RETRY_LIM) fault <= 1'b1;
      end
    end
  end

endmodule
